// File: rtl/wb_regfile_pkg.sv
// Core-wide register file constants, shared with the ID/EX forwarding
// and hazard units.
package wb_regfile_pkg;

    localparam int DW       = 32;
    localparam int AW       = 5;
    localparam int NUM_REGS = 32;

    localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/wb_regfile.sv
// Writeback stage and register file: selects the writeback value, commits
// it, serves two write-through read ports and counts retired writes.
module wb_regfile #(
    parameter int DW   = wb_regfile_pkg::DW,
    parameter int AW   = wb_regfile_pkg::AW,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            M2R,
    input  logic            RegWr,
    input  logic [DW-1:0]   MEMData,
    input  logic [DW-1:0]   ALUOut,
    input  logic [AW-1:0]   MEMWB_Rd,
    input  logic [AW-1:0]   rs_addr,
    input  logic [AW-1:0]   rt_addr,
    output logic [DW-1:0]   rs_data,
    output logic [DW-1:0]   rt_data,
    output logic [DW-1:0]   wb_data,
    output logic            wb_valid,
    output logic [CNTW-1:0] retire_cnt
);

    import wb_regfile_pkg::*;

    localparam int NR = 2 ** AW;

    localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

    logic [DW-1:0]   regs_q [NR];
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;

    always_comb begin
        wb_data  = M2R ? MEMData : ALUOut;
        wb_valid = RegWr && (MEMWB_Rd != ZR);
        cnt_d    = cnt_q + CNTW'(1);
    end

    // Write-through bypass removes the WB->ID hazard; r0 always reads zero.
    always_comb begin
        rs_data = regs_q[rs_addr];
        if (rs_addr == ZR) begin
            rs_data = '0;
        end else if (wb_valid && (rs_addr == MEMWB_Rd)) begin
            rs_data = wb_data;
        end
    end

    always_comb begin
        rt_data = regs_q[rt_addr];
        if (rt_addr == ZR) begin
            rt_data = '0;
        end else if (wb_valid && (rt_addr == MEMWB_Rd)) begin
            rt_data = wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NR; i++) begin
                regs_q[i] <= '0;
            end
            cnt_q <= '0;
        end else if (wb_valid) begin
            regs_q[MEMWB_Rd] <= wb_data;
            cnt_q            <= cnt_d;
        end
    end

    assign retire_cnt = cnt_q;

endmodule
